// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, X/Y counters, explicit
// horizontal/vertical region FSMs and registered blank/sync/tick outputs.
module vga_timing_gen #(
  parameter int CLKDIV    = 2,
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BACK    = 64,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 23,
  parameter int SYNC_POL  = 1
) (
  input  logic        CLK_100MHz,
  input  logic        RESET,
  input  logic        ENABLE,
  output logic [10:0] CurrentX,
  output logic [10:0] CurrentY,
  output logic        HBlank,
  output logic        VBlank,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        PixelTick,
  output logic        FrameStart
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048 || CLKDIV < 1) begin : g_bad_params
      $error("vga_timing_gen: totals must fit 11 bits and CLKDIV must be >= 1");
    end
  endgenerate

  localparam logic [4:0]  PH_LAST   = 5'(CLKDIV - 1);
  localparam logic [10:0] X_ACT_END = 11'(H_VISIBLE - 1);
  localparam logic [10:0] X_FP_END  = 11'(H_VISIBLE + H_FRONT - 1);
  localparam logic [10:0] X_SY_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] X_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] Y_ACT_END = 11'(V_VISIBLE - 1);
  localparam logic [10:0] Y_FP_END  = 11'(V_VISIBLE + V_FRONT - 1);
  localparam logic [10:0] Y_SY_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [10:0] Y_LAST    = 11'(V_TOTAL - 1);
  localparam logic        SYNC_ON   = (SYNC_POL != 0);

  typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_t;

  logic [4:0]  phase_q, phase_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  h_state_t    h_state_q, h_state_d;
  v_state_t    v_state_q, v_state_d;
  logic        hblank_q, hblank_d, vblank_q, vblank_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        tick_q, tick_d, frame_q, frame_d;
  logic        adv, line_end;

  always_comb begin
    phase_d   = phase_q;
    x_d       = x_q;
    y_d       = y_q;
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    tick_d    = 1'b0;
    frame_d   = 1'b0;
    adv       = 1'b0;
    line_end  = 1'b0;

    if (ENABLE) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
        adv     = 1'b1;
      end else begin
        phase_d = phase_q + 5'd1;
      end
    end

    if (adv) begin
      tick_d = 1'b1;
      if (x_q == X_LAST) begin
        x_d      = '0;
        line_end = 1'b1;
      end else begin
        x_d = x_q + 11'd1;
      end
      case (h_state_q)
        H_ACT:   if (x_q == X_ACT_END) h_state_d = H_FP;
        H_FP:    if (x_q == X_FP_END)  h_state_d = H_SY;
        H_SY:    if (x_q == X_SY_END)  h_state_d = H_BP;
        default: if (line_end)         h_state_d = H_ACT;
      endcase

      // Vertical side moves only on the line-end strobe
      if (line_end) begin
        if (y_q == Y_LAST) begin
          y_d     = '0;
          frame_d = 1'b1;
        end else begin
          y_d = y_q + 11'd1;
        end
        case (v_state_q)
          V_ACT:   if (y_q == Y_ACT_END) v_state_d = V_FP;
          V_FP:    if (y_q == Y_FP_END)  v_state_d = V_SY;
          V_SY:    if (y_q == Y_SY_END)  v_state_d = V_BP;
          default: if (y_q == Y_LAST)    v_state_d = V_ACT;
        endcase
      end
    end

    // Decode from next state so flags land in the same cycle as the counters
    hblank_d = (h_state_d != H_ACT);
    vblank_d = (v_state_d != V_ACT);
    hsync_d  = (h_state_d == H_SY) ? SYNC_ON : ~SYNC_ON;
    vsync_d  = (v_state_d == V_SY) ? SYNC_ON : ~SYNC_ON;
  end

  always_ff @(posedge CLK_100MHz) begin
    if (RESET) begin
      phase_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      h_state_q <= H_ACT;
      v_state_q <= V_ACT;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
      hsync_q   <= ~SYNC_ON;
      vsync_q   <= ~SYNC_ON;
      tick_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      x_q       <= x_d;
      y_q       <= y_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      tick_q    <= tick_d;
      frame_q   <= frame_d;
    end
  end

  assign CurrentX   = x_q;
  assign CurrentY   = y_q;
  assign HBlank     = hblank_q;
  assign VBlank     = vblank_q;
  assign HSYNC      = hsync_q;
  assign VSYNC      = vsync_q;
  assign PixelTick  = tick_q;
  assign FrameStart = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations driven by shared RESET/ENABLE,
// checked against an arithmetic raster model built on a count of enabled clocks.
module tb_vga_timing_gen;

  logic clk, rst, ena;
  int   passed, total;

  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic hb_a, vb_a, hs_a, vs_a, pt_a, fs_a;
  logic hb_b, vb_b, hs_b, vs_b, pt_b, fs_b;
  logic hb_c, vb_c, hs_c, vs_c, pt_c, fs_c;

  vga_timing_gen dut_a (
    .CLK_100MHz(clk), .RESET(rst), .ENABLE(ena),
    .CurrentX(x_a), .CurrentY(y_a), .HBlank(hb_a), .VBlank(vb_a),
    .HSYNC(hs_a), .VSYNC(vs_a), .PixelTick(pt_a), .FrameStart(fs_a));

  vga_timing_gen #(.CLKDIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(0)) dut_b (
    .CLK_100MHz(clk), .RESET(rst), .ENABLE(ena),
    .CurrentX(x_b), .CurrentY(y_b), .HBlank(hb_b), .VBlank(vb_b),
    .HSYNC(hs_b), .VSYNC(vs_b), .PixelTick(pt_b), .FrameStart(fs_b));

  vga_timing_gen #(.CLKDIV(3), .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(5), .V_FRONT(2), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1)) dut_c (
    .CLK_100MHz(clk), .RESET(rst), .ENABLE(ena),
    .CurrentX(x_c), .CurrentY(y_c), .HBlank(hb_c), .VBlank(vb_c),
    .HSYNC(hs_c), .VSYNC(vs_c), .PixelTick(pt_c), .FrameStart(fs_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: n enabled clocks since reset => n/CLKDIV pixels have elapsed.
  longint n;
  bit     en_last;
  initial begin n = 0; en_last = 0; end
  always @(posedge clk) begin
    if (rst) begin
      n <= 0; en_last <= 1'b0;
    end else begin
      en_last <= ena;
      if (ena) n <= n + 1;
    end
  end

  function automatic logic [27:0] model(input longint cnt, input bit adv_clk, input int cd,
      input int hv, input int hf, input int hs, input int hbk,
      input int vv, input int vf, input int vs, input int vbk, input int pol);
    longint p, x, y;
    int ht, vt;
    bit tick, fs, hbl, vbl, hsy, vsy;
    ht   = hv + hf + hs + hbk;
    vt   = vv + vf + vs + vbk;
    p    = cnt / cd;
    x    = p % ht;
    y    = (p / ht) % vt;
    tick = adv_clk && (cnt % cd == 0);
    fs   = tick && (p % (ht * vt) == 0);
    hbl  = (x >= hv);
    vbl  = (y >= vv);
    hsy  = (x >= hv + hf && x < hv + hf + hs) ? (pol != 0) : (pol == 0);
    vsy  = (y >= vv + vf && y < vv + vf + vs) ? (pol != 0) : (pol == 0);
    return {x[10:0], y[10:0], hbl, vbl, hsy, vsy, tick, fs};
  endfunction

  logic [27:0] act_a, act_b, act_c, exp_a, exp_b, exp_c;
  assign act_a = {x_a, y_a, hb_a, vb_a, hs_a, vs_a, pt_a, fs_a};
  assign act_b = {x_b, y_b, hb_b, vb_b, hs_b, vs_b, pt_b, fs_b};
  assign act_c = {x_c, y_c, hb_c, vb_c, hs_c, vs_c, pt_c, fs_c};
  always_comb begin
    exp_a = model(n, en_last, 2, 800, 56, 120, 64, 600, 37, 6, 23, 1);
    exp_b = model(n, en_last, 1, 8, 2, 3, 1, 4, 1, 1, 1, 0);
    exp_c = model(n, en_last, 3, 10, 2, 3, 2, 5, 2, 2, 1, 1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1;
    repeat (5) step();
    total++;
    if (act_a !== 28'h0) $display("FAIL reset_a: got %h expected %h", act_a, 28'h0);
    else passed++;
    total++;
    if (act_b !== 28'hC) $display("FAIL reset_b: got %h expected %h", act_b, 28'hC);
    else passed++;
    total++;
    if (act_c !== 28'h0) $display("FAIL reset_c: got %h expected %h", act_c, 28'h0);
    else passed++;
    rst = 1'b0;
    step();
    total++;
    if (act_a !== 28'h0) $display("FAIL release_first_clk: got %h expected %h", act_a, 28'h0);
    else passed++;
    step();
    total++;
    if ({x_a, pt_a, fs_a} !== {11'd1, 1'b1, 1'b0})
      $display("FAIL first_tick: got x=%0d tick=%b fs=%b expected x=1 tick=1 fs=0", x_a, pt_a, fs_a);
    else passed++;
  endtask

  task automatic test_hline();
    int cyc, hb_rise, hs_cnt, wraps;
    logic [10:0] prev_x;
    cyc = 2; hb_rise = -1; hs_cnt = 0; wraps = 0;
    for (int i = 0; i < 2200; i++) begin
      prev_x = x_a;
      step();
      cyc++;
      total++;
      if (act_a !== exp_a) $display("FAIL hline_model cyc=%0d: got %h expected %h", cyc, act_a, exp_a);
      else passed++;
      if (hb_rise < 0 && hb_a) hb_rise = cyc;
      if (hs_a && y_a == 11'd0) hs_cnt++;
      if (prev_x == 11'd1039 && x_a == 11'd0) begin
        wraps++;
        total++;
        if (y_a !== 11'd1) $display("FAIL line_wrap_y: got %0d expected 1", y_a);
        else passed++;
      end
    end
    total++;
    if (hb_rise != 1600) $display("FAIL hblank_rise: got %0d expected 1600", hb_rise);
    else passed++;
    total++;
    if (hs_cnt != 240) $display("FAIL hsync_width: got %0d expected 240", hs_cnt);
    else passed++;
    total++;
    if (wraps != 1) $display("FAIL line_wrap_count: got %0d expected 1", wraps);
    else passed++;
  endtask

  task automatic test_enable_gating();
    bit found;
    logic [27:0] saved;
    int got0, got1, k;
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      if (x_a == 11'd500 && pt_a) found = 1;
    end
    total++;
    if (!found) $display("FAIL reach_x500: got timeout expected X=500");
    else passed++;
    saved = act_a;
    ena = 1'b0;
    for (int i = 0; i < 37; i++) begin
      step();
      total++;
      if (act_a !== {saved[27:2], 2'b00})
        $display("FAIL enable_hold i=%0d: got %h expected %h", i, act_a, {saved[27:2], 2'b00});
      else passed++;
    end
    ena = 1'b1;
    got0 = -1; got1 = -1; k = 0;
    for (int i = 0; i < 10 && k < 2; i++) begin
      step();
      if (pt_a) begin
        if (k == 0) got0 = int'(x_a); else got1 = int'(x_a);
        k++;
      end
    end
    total++;
    if (got0 != 501) $display("FAIL resume_x1: got %0d expected 501", got0);
    else passed++;
    total++;
    if (got1 != 502) $display("FAIL resume_x2: got %0d expected 502", got1);
    else passed++;
    total++;
    if (act_a !== exp_a) $display("FAIL resume_model: got %h expected %h", act_a, exp_a);
    else passed++;
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 4000; i++) begin
      ena = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
      total++;
      if (act_a !== exp_a) $display("FAIL rand_a i=%0d: got %h expected %h", i, act_a, exp_a);
      else passed++;
      total++;
      if (act_b !== exp_b) $display("FAIL rand_b i=%0d: got %h expected %h", i, act_b, exp_b);
      else passed++;
      total++;
      if (act_c !== exp_c) $display("FAIL rand_c i=%0d: got %h expected %h", i, act_c, exp_c);
      else passed++;
    end
    rst = 1'b0; ena = 1'b1;
  endtask

  task automatic test_frame();
    int cyc, first_b, first_c, cnt_b, cnt_c;
    rst = 1'b1; ena = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0; first_b = -1; first_c = -1; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      cyc++;
      total++;
      if (act_b !== exp_b) $display("FAIL frame_b cyc=%0d: got %h expected %h", cyc, act_b, exp_b);
      else passed++;
      total++;
      if (act_c !== exp_c) $display("FAIL frame_c cyc=%0d: got %h expected %h", cyc, act_c, exp_c);
      else passed++;
      if (fs_b) begin
        cnt_b++;
        if (first_b < 0) first_b = cyc;
        total++;
        if ({x_b, y_b, pt_b} !== {22'd0, 1'b1})
          $display("FAIL fs_origin_b: got x=%0d y=%0d tick=%b expected 0 0 1", x_b, y_b, pt_b);
        else passed++;
      end
      if (fs_c) begin
        cnt_c++;
        if (first_c < 0) first_c = cyc;
      end
    end
    total++;
    if (first_b != 98) $display("FAIL frame_period_b: got %0d expected 98", first_b);
    else passed++;
    total++;
    if (cnt_b != 11) $display("FAIL frame_count_b: got %0d expected 11", cnt_b);
    else passed++;
    total++;
    if (first_c != 510) $display("FAIL frame_period_c: got %0d expected 510", first_c);
    else passed++;
    total++;
    if (cnt_c != 2) $display("FAIL frame_count_c: got %0d expected 2", cnt_c);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (x_b >= 11'd10 && x_b <= 11'd12 && y_b == 11'd5) found = 1;
    end
    total++;
    if (!found || hs_b !== 1'b0 || vs_b !== 1'b0)
      $display("FAIL reach_sync_b: got found=%0d hs=%b vs=%b expected 1 0 0", found, hs_b, vs_b);
    else passed++;
    rst = 1'b1; ena = 1'b0;
    step();
    total++;
    if (act_b !== 28'hC) $display("FAIL midreset_b: got %h expected %h", act_b, 28'hC);
    else passed++;
    total++;
    if (act_a !== 28'h0) $display("FAIL midreset_a: got %h expected %h", act_a, 28'h0);
    else passed++;
    rst = 1'b0; ena = 1'b1;
    step();
    total++;
    if ({x_b, pt_b, fs_b} !== {11'd1, 1'b1, 1'b0})
      $display("FAIL post_reset_b: got x=%0d tick=%b fs=%b expected 1 1 0", x_b, pt_b, fs_b);
    else passed++;
    total++;
    if (act_a !== 28'h0) $display("FAIL post_reset_a: got %h expected %h", act_a, 28'h0);
    else passed++;
    step();
    total++;
    if ({x_a, pt_a} !== {11'd1, 1'b1})
      $display("FAIL post_reset_a_tick: got x=%0d tick=%b expected 1 1", x_a, pt_a);
    else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1'b1; ena = 1'b1;
    test_reset();
    test_hline();
    test_enable_gating();
    test_random_enable();
    test_frame();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
